// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int         DEF_TIMEOUT_CYCLES = 64;
    localparam logic [7:0] DEF_ERR_DATA       = 8'hFF;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counter loaded with zero on clear, counts while enabled and
// flags the terminal count TIMEOUT_CYCLES-1.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int            CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Holds at terminal count so the count can never wrap back to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == TC);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master single-beat Wishbone arbiter between the 6502 bridge (m0) and the
// loader/debug master (m1), with a watchdog that completes unacknowledged cycles.
module wb_master_arbiter import wb_arb_pkg::*; #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int                    FIXED_PRIORITY = 0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic                  m0_ack_o,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic                  m1_ack_o,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic                  s_ack_i,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  err_clr_i,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH-1:0] timeout_adr_o,
    output logic [1:0]            grant_o
);

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic                  r_last_grant;   // 1 = master 1 completed last
    logic                  r_timeout;
    logic [ADDR_WIDTH-1:0] r_timeout_adr;

    logic                  w_granted;
    logic                  w_sel_m1;
    logic                  w_req;
    logic                  w_ack;
    logic [DATA_WIDTH-1:0] w_rdat;
    logic                  w_done;
    logic                  w_to;
    logic                  w_tc;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .i_clr (r_state == ST_IDLE),
        .i_en  (w_granted),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_timeout     <= 1'b0;
            r_timeout_adr <= '0;
        end else begin
            r_state <= w_next;
            if (w_done) begin
                r_last_grant <= w_sel_m1;
            end
            if (w_to) begin
                r_timeout     <= 1'b1;
                r_timeout_adr <= s_adr_o;
            end else if (err_clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Reset gates everything so an in-flight cycle is dropped without an ack.
    always_comb begin
        w_next    = r_state;
        w_granted = 1'b0;
        w_sel_m1  = (r_state == ST_GRANT1);
        w_req     = 1'b0;
        w_ack     = 1'b0;
        w_rdat    = '0;
        w_done    = 1'b0;
        w_to      = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        grant_o   = GNT_NONE;
        if (!reset) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (m0_stb_i && m1_stb_i) begin
                        w_next = (FIXED_PRIORITY != 0 || r_last_grant) ? ST_GRANT0 : ST_GRANT1;
                    end else if (m0_stb_i) begin
                        w_next = ST_GRANT0;
                    end else if (m1_stb_i) begin
                        w_next = ST_GRANT1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    w_granted = 1'b1;
                    grant_o   = w_sel_m1 ? GNT_M1 : GNT_M0;
                    w_req     = w_sel_m1 ? m1_stb_i : m0_stb_i;
                    s_stb_o   = w_req;
                    s_we_o    = w_sel_m1 ? m1_we_i  : m0_we_i;
                    s_adr_o   = w_sel_m1 ? m1_adr_i : m0_adr_i;
                    s_dat_o   = w_sel_m1 ? m1_dat_i : m0_dat_i;
                    w_rdat    = s_dat_i;
                    if (!w_req) begin
                        w_next = ST_IDLE;
                    end else if (s_ack_i) begin
                        w_ack  = 1'b1;
                        w_done = 1'b1;
                        w_next = ST_IDLE;
                    end else if (w_tc) begin
                        w_ack  = 1'b1;
                        w_rdat = ERR_DATA;
                        w_done = 1'b1;
                        w_to   = 1'b1;
                        w_next = ST_IDLE;
                    end
                    if (w_sel_m1) begin
                        m1_ack_o = w_ack;
                        m1_dat_o = w_rdat;
                    end else begin
                        m0_ack_o = w_ack;
                        m0_dat_o = w_rdat;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    assign timeout_o     = r_timeout;
    assign timeout_adr_o = r_timeout_adr;

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone arbiter that shares the single 8-bit/16-bit-address system bus between the 6502 bridge (master 0) and a secondary master (master 1: cartridge loader / debug port). It sits between the masters and the address-decoding bus interconnect, granting one single-beat transaction at a time. A bus watchdog ensures a missing slave acknowledge never hangs the CPU.

## Interface
Parameters:
- ADDR_WIDTH, 16, address width of both masters and bus
- DATA_WIDTH, 8, data width
- TIMEOUT_CYCLES, 64, cycles in GRANT without ack before forced completion (min 2)
- FIXED_PRIORITY, 0, 0 = round-robin on ties, 1 = master 0 always wins ties
- ERR_DATA, 8'hFF, read data returned on a timed-out cycle

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- m0_stb_i / m1_stb_i  in  1  master strobe, held until ack
- m0_we_i / m1_we_i  in  1  write enable
- m0_adr_i / m1_adr_i  in  ADDR_WIDTH  address
- m0_dat_i / m1_dat_i  in  DATA_WIDTH  write data
- m0_ack_o / m1_ack_o  out  1  acknowledge to master
- m0_dat_o / m1_dat_o  out  DATA_WIDTH  read data to master
- s_stb_o  out  1  strobe to interconnect
- s_we_o  out  1  write enable to interconnect
- s_adr_o  out  ADDR_WIDTH  address to interconnect
- s_dat_o  out  DATA_WIDTH  write data to interconnect
- s_ack_i  in  1  acknowledge from interconnect
- s_dat_i  in  DATA_WIDTH  read data from interconnect
- err_clr_i  in  1  clears timeout_o
- timeout_o  out  1  sticky: a timeout occurred
- timeout_adr_o  out  ADDR_WIDTH  address of most recent timed-out cycle
- grant_o  out  2  one-hot current grant (debug)

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE: s_stb_o=0. If exactly one stb_i high -> GRANT of that master. Both high -> FIXED_PRIORITY=1: GRANT0; else the master not granted last (last_grant register).
- GRANTx: s_stb_o/we/adr/dat driven from master x combinationally; mx_ack_o = s_ack_i, mx_dat_o = s_dat_i; other master's ack_o=0. On s_ack_i -> IDLE, last_grant<=x.
- Granted master dropping stb before ack (protocol violation): s_stb_o follows low, arbiter returns to IDLE next cycle, no ack issued.
- Watchdog: counter cleared on entry to GRANTx, increments each GRANT cycle. When count reaches TIMEOUT_CYCLES-1 without s_ack_i: mx_ack_o=1 for one cycle with mx_dat_o=ERR_DATA, timeout_o<=1, timeout_adr_o<=s_adr_o, -> IDLE. s_ack_i in the same cycle wins (normal completion, no error).
- err_clr_i clears timeout_o; simultaneous new timeout wins (stays 1).
- Non-granted master data outputs: 0. Master 1 is never starved with FIXED_PRIORITY=0.

## Timing
- Reset values: state IDLE, all ack_o 0, dat_o 0, s_stb_o/s_we_o 0, s_adr_o/s_dat_o 0, timeout_o 0, timeout_adr_o 0, grant_o 2'b00, last_grant = master 1 (first tie goes to master 0), counter 0.
- Reset mid-transaction: abandon immediately, no ack issued.
- Request in IDLE at cycle N -> s_stb_o high in N+1. Ack combinational (same cycle as s_ack_i). IDLE for ≥1 cycle between transactions: min 3 cycles per transaction with 1-cycle slave ack.
- Timeout ack occurs in the TIMEOUT_CYCLES-th GRANT cycle.

## Structure
- Package wb_arb_pkg: state enum, grant one-hot constants, default TIMEOUT_CYCLES and ERR_DATA.
- Sub-module wb_arb_watchdog: loadable counter with clear, enable and terminal-count output, width $clog2(TIMEOUT_CYCLES).
- Output mux and FSM in top level.

## Test plan
- m0 read of 0xF000, slave acks after 2 cycles with 0xA9 -> s_stb_o from N+1, m0_ack_o with m0_dat_o=0xA9, m1_ack_o stays 0.
- Both request continuously, FIXED_PRIORITY=0, from reset -> grants alternate 0,1,0,1; with FIXED_PRIORITY=1 m0 wins every tie.
- m1 write 0x55 to 0x0080 while m0 idle -> s_we_o=1, s_dat_o=0x55, s_adr_o=0x0080, m1_ack_o on s_ack_i.
- m0 read of unmapped 0x1234, no ack, TIMEOUT_CYCLES=64 -> m0_ack_o in 64th grant cycle, m0_dat_o=0xFF, timeout_o=1, timeout_adr_o=0x1234; err_clr_i pulse -> timeout_o=0.
- s_ack_i in exact terminal-count cycle -> normal data, timeout_o stays 0.
- reset asserted during GRANT1 -> next cycle all outputs at reset values, no ack to m1.
